// File: rtl/gauss_pkg.sv
// Shared definitions for the 3x3 Gaussian blur block: widths, the kernel
// expressed as shift amounts, and the controller state encoding.
package gauss_pkg;

    localparam int DW     = 8;    // pixel width
    localparam int ACCW   = 12;   // accumulator width (max sum 4080)
    localparam int SHIFT  = 4;    // normalise by 16
    localparam int N_TAPS = 9;

    // Tap index of the final weighted term, and the index reached once all
    // nine terms have been added.
    localparam logic [3:0] LAST_TAP = 4'd8;
    localparam logic [3:0] TAP_DONE = 4'd9;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1 as left-shift amounts, tap 0 in bits [1:0]
    // (the concatenation lists tap 8 first).
    localparam logic [2*N_TAPS-1:0] KERNEL_SHIFT = {
        2'd0, 2'd1, 2'd0,
        2'd1, 2'd2, 2'd1,
        2'd0, 2'd1, 2'd0
    };

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        ACC,
        DONE
    } state_t;

    // Shift amount for a tap; taps beyond the window weigh nothing.
    function automatic logic [1:0] tap_shift(input logic [3:0] idx);
        tap_shift = 2'd0;
        if (idx <= LAST_TAP) begin
            tap_shift = KERNEL_SHIFT[2*int'(idx) +: 2];
        end
    endfunction

endpackage

// File: rtl/gauss_tap_acc.sv
// Sequential weighted accumulator: adds pix << shamt to a registered sum
// once per enabled cycle; clear has priority over add.
module gauss_tap_acc
    import gauss_pkg::*;
#(
    parameter int DW   = gauss_pkg::DW,
    parameter int ACCW = gauss_pkg::ACCW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr,
    input  logic            add_en,
    input  logic [DW-1:0]   pix,
    input  logic [1:0]      shamt,
    output logic [ACCW-1:0] sum
);

    logic [ACCW-1:0] term;

    // Weights are powers of two, so each product is just a shift.
    assign term = ACCW'(pix) << shamt;

    // Running sum of weighted taps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst_i) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + term;
        end
    end

endmodule

// File: rtl/gauss_2.sv
// 3x3 Gaussian blur of one pixel window. A five-state controller waits a
// settle cycle, captures the window, accumulates one weighted tap per cycle
// and then presents the normalised result until the request is withdrawn.
module gauss_2
    import gauss_pkg::*;
#(
    parameter int DW    = gauss_pkg::DW,
    parameter int ACCW  = gauss_pkg::ACCW,
    parameter int SHIFT = gauss_pkg::SHIFT
) (
    input  logic          clk_i_g,
    input  logic          rst_i_g,
    input  logic          en_i_g,
    input  logic [DW-1:0] data_i_0,
    input  logic [DW-1:0] data_i_1,
    input  logic [DW-1:0] data_i_2,
    input  logic [DW-1:0] data_i_3,
    input  logic [DW-1:0] data_i_4,
    input  logic [DW-1:0] data_i_5,
    input  logic [DW-1:0] data_i_6,
    input  logic [DW-1:0] data_i_7,
    input  logic [DW-1:0] data_i_8,
    output logic [DW-1:0] data_o,
    output logic          sonuc_done
);

    state_t          state;
    logic [3:0]      tap_idx;
    logic [DW-1:0]   win  [N_TAPS];
    logic [DW-1:0]   ops  [N_TAPS];
    logic [DW-1:0]   tap_pix;
    logic [1:0]      tap_shamt;
    logic            acc_clr;
    logic            acc_add;
    logic [ACCW-1:0] acc_sum;

    assign win[0] = data_i_0;
    assign win[1] = data_i_1;
    assign win[2] = data_i_2;
    assign win[3] = data_i_3;
    assign win[4] = data_i_4;
    assign win[5] = data_i_5;
    assign win[6] = data_i_6;
    assign win[7] = data_i_7;
    assign win[8] = data_i_8;

    // Select the captured operand for the current tap.
    always_comb begin
        // NOTE: default first so no path leaves tap_pix unassigned (no latch).
        tap_pix = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (tap_idx == 4'(k)) begin
                tap_pix = ops[k];
            end
        end
    end

    assign tap_shamt = tap_shift(tap_idx);
    assign acc_clr   = (state == LOAD);
    assign acc_add   = (state == ACC) && en_i_g && (tap_idx <= LAST_TAP);

    gauss_tap_acc #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_tap_acc (
        .clk_i  (clk_i_g),
        .rst_i  (rst_i_g),
        .clr    (acc_clr),
        .add_en (acc_add),
        .pix    (tap_pix),
        .shamt  (tap_shamt),
        .sum    (acc_sum)
    );

    // Controller, operand capture and result registers.
    always_ff @(posedge clk_i_g or posedge rst_i_g) begin
        if (rst_i_g) begin
            state      <= IDLE;
            tap_idx    <= '0;
            data_o     <= '0;
            sonuc_done <= 1'b0;
            // NOTE: the nine-entry operand file is small and must read as zero
            // after reset, so it is reset like ordinary flops rather than
            // treated as an unreset memory.
            for (int k = 0; k < N_TAPS; k++) begin
                ops[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    sonuc_done <= 1'b0;
                    if (en_i_g) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state <= en_i_g ? LOAD : IDLE;
                end
                LOAD: begin
                    if (!en_i_g) begin
                        state <= IDLE;
                    end else begin
                        ops     <= win;
                        tap_idx <= '0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    // The extra pass at TAP_DONE waits for the registered sum
                    // that includes tap 8 before it is published.
                    if (!en_i_g) begin
                        state <= IDLE;
                    end else if (tap_idx == TAP_DONE) begin
                        data_o     <= DW'(acc_sum >> SHIFT);
                        sonuc_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tap_idx <= tap_idx + 4'd1;
                    end
                end
                DONE: begin
                    if (!en_i_g) begin
                        sonuc_done <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_2.sv
// Self-checking bench for gauss_2: directed corner cases plus random windows,
// compared against a plain-arithmetic model of the 3x3 Gaussian kernel.
module tb_gauss_2;

    logic       clk_i_g = 1'b0;
    logic       rst_i_g;
    logic       en_i_g;
    logic [7:0] px [9];
    logic [7:0] data_o;
    logic       sonuc_done;

    int n_cmp = 0;
    int n_mis = 0;
    int last_exp = 0;

    gauss_2 dut (
        .clk_i_g    (clk_i_g),
        .rst_i_g    (rst_i_g),
        .en_i_g     (en_i_g),
        .data_i_0   (px[0]),
        .data_i_1   (px[1]),
        .data_i_2   (px[2]),
        .data_i_3   (px[3]),
        .data_i_4   (px[4]),
        .data_i_5   (px[5]),
        .data_i_6   (px[6]),
        .data_i_7   (px[7]),
        .data_i_8   (px[8]),
        .data_o     (data_o),
        .sonuc_done (sonuc_done)
    );

    always #5 clk_i_g = ~clk_i_g;

    // Reference: weighted sum with the textbook kernel, integer divide by 16.
    function automatic int ref_gauss();
        int w [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int k = 0; k < 9; k++) s += w[k] * int'(px[k]);
        return s / 16;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i_g);
        #1;
    endtask

    task automatic set_px(input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int a6, input int a7,
                          input int a8);
        px[0] = 8'(a0); px[1] = 8'(a1); px[2] = 8'(a2);
        px[3] = 8'(a3); px[4] = 8'(a4); px[5] = 8'(a5);
        px[6] = 8'(a6); px[7] = 8'(a7); px[8] = 8'(a8);
    endtask

    task automatic rand_px();
        for (int k = 0; k < 9; k++) px[k] = 8'($urandom_range(0, 255));
    endtask

    // Raise en and run one full operation; done must stay low for the first
    // 12 edges and be high right after edge 12. If mutate_at >= 0 the window
    // is re-randomised after that edge (0 = edge that first samples en).
    task automatic run_op(input string tag, input int mutate_at);
        int exp;
        exp = ref_gauss();
        en_i_g = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check({tag, "/done_early"}, 16'(sonuc_done), 16'd0);
            if (i == mutate_at) rand_px();
        end
        tick();
        check({tag, "/done"}, 16'(sonuc_done), 16'd1);
        check({tag, "/data"}, 16'(data_o), 16'(exp));
        last_exp = exp;
    endtask

    // Withdraw the request; done must clear on the next edge, data held.
    task automatic end_op(input string tag);
        en_i_g = 1'b0;
        tick();
        check({tag, "/done_clr"}, 16'(sonuc_done), 16'd0);
        check({tag, "/data_hold"}, 16'(data_o), 16'(last_exp));
    endtask

    // Start an operation, drop en after n_high sampled edges, and confirm
    // that no result is ever produced and data_o is untouched.
    task automatic abort_op(input string tag, input int n_high);
        rand_px();
        en_i_g = 1'b1;
        for (int i = 0; i < n_high; i++) tick();
        en_i_g = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check({tag, "/no_done"}, 16'(sonuc_done), 16'd0);
        end
        check({tag, "/data_kept"}, 16'(data_o), 16'(last_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i_g = 1'b1;
        en_i_g  = 1'b0;
        set_px(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset/data", 16'(data_o), 16'd0);
        check("reset/done", 16'(sonuc_done), 16'd0);
        rst_i_g = 1'b0;
        tick();
        check("idle/done", 16'(sonuc_done), 16'd0);

        // All-255 window: maximum sum, exact 12-cycle latency.
        set_px(255, 255, 255, 255, 255, 255, 255, 255, 255);
        run_op("max", -1);

        // Hold en 30 cycles past done: flag and data stable.
        for (int i = 0; i < 30; i++) begin
            tick();
            check("hold/done", 16'(sonuc_done), 16'd1);
            check("hold/data", 16'(data_o), 16'(last_exp));
        end
        end_op("max");
        tick();
        tick();
        check("gap/done", 16'(sonuc_done), 16'd0);

        // Re-raise after the idle gap: ramp window, sum 800.
        set_px(10, 20, 30, 40, 50, 60, 70, 80, 90);
        run_op("ramp", -1);
        end_op("ramp");

        // Back-to-back with no idle gap: centre-only truncation case.
        set_px(0, 0, 0, 0, 255, 0, 0, 0, 0);
        run_op("centre", -1);
        end_op("centre");

        // Corner-only weight-1 tap.
        set_px(16, 0, 0, 0, 0, 0, 0, 0, 0);
        run_op("corner", -1);
        end_op("corner");

        // Opposite corner and edge taps separately to exercise each weight.
        set_px(0, 0, 0, 0, 0, 0, 0, 0, 200);
        run_op("corner8", -1);
        end_op("corner8");
        set_px(0, 0, 0, 0, 0, 0, 0, 240, 0);
        run_op("edge7", -1);
        end_op("edge7");

        // Inputs change two cycles after the capture edge.
        rand_px();
        run_op("mutate", 4);
        end_op("mutate");
        rand_px();
        run_op("mutate_early", 2);
        end_op("mutate_early");

        // Aborts in WAIT, LOAD, mid-ACC, and on the publish cycle.
        abort_op("abort_wait", 1);
        abort_op("abort_load", 2);
        abort_op("abort_c5", 5);
        abort_op("abort_last", 12);

        // Recovery after aborts.
        rand_px();
        run_op("recover", -1);
        end_op("recover");

        // Reset in the middle of an operation: outputs clear immediately.
        rand_px();
        en_i_g = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_i_g = 1'b1;
        #1;
        check("midrst/data", 16'(data_o), 16'd0);
        check("midrst/done", 16'(sonuc_done), 16'd0);
        en_i_g = 1'b0;
        tick();
        rst_i_g = 1'b0;
        last_exp = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("postrst/done", 16'(sonuc_done), 16'd0);
        end
        check("postrst/data", 16'(data_o), 16'd0);

        // Random windows, chained with no idle gap.
        for (int r = 0; r < 8; r++) begin
            rand_px();
            run_op("rand", -1);
            end_op("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gauss_2.md
GAUSS_2 -- requirements
Module: gauss_2

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the clock port SHALL be clk_i_g and the reset port SHALL be rst_i_g.
REQ-002 Port list (name, direction, width, meaning), in this order:
- clk_i_g, in, 1: rising-edge clock.
- rst_i_g, in, 1: asynchronous active-high reset.
- en_i_g, in, 1: start/hold request; high requests one filtered pixel.
- data_i_0 … data_i_8, in, 8 each: unsigned 3x3 window, row-major; 0 is top-left, 4 is centre, 8 is bottom-right.
- data_o, out, 8: filtered pixel, registered.
- sonuc_done, out, 1: result-valid flag, registered.
REQ-003 Parameter list (name, default, meaning):
- DW, 8: pixel width.
- ACCW, 12: accumulator width.
- SHIFT, 4: normalisation shift, i.e. divide by 16.

Function
REQ-004 Kernel weights SHALL be 1 2 1 / 2 4 2 / 1 2 1, applied to data_i_0..8 in that order.
REQ-005 Result SHALL be data_o = floor(sum(w_k * data_i_k) / 16), i.e. the accumulator shifted right by 4, truncating with no rounding.
REQ-006 Sums SHALL be unsigned; the maximum is 4080, which fits in 12 bits, so no saturation is needed and data_o SHALL never exceed 255.
REQ-007 FSM states: IDLE, WAIT, LOAD, ACC, DONE.
REQ-008 IDLE: when en_i_g=1, go to WAIT; otherwise stay in IDLE.
REQ-009 WAIT: one cycle that lets the upstream stage settle its data; then go to LOAD.
REQ-010 LOAD: capture all nine inputs into internal registers, clear the accumulator and tap index, then go to ACC.
REQ-011 ACC: add one weighted tap per cycle, taps 0..8 over 9 cycles; weights are realised as shifts (x1, x2 = <<1, x4 = <<2), with no multipliers; after tap 8, go to DONE.
REQ-012 Entering DONE: register data_o from the final sum and set sonuc_done=1.
REQ-013 Latency: sonuc_done SHALL rise exactly 12 cycles after the first rising edge that samples en_i_g=1.
REQ-014 DONE: hold data_o and sonuc_done=1 while en_i_g=1; when en_i_g=0, clear sonuc_done and go to IDLE.
REQ-015 data_o SHALL keep its last value until the next DONE entry.
REQ-016 If en_i_g falls in WAIT, LOAD or ACC, the operation SHALL be aborted: return to IDLE, leave sonuc_done=0 and leave data_o unchanged.
REQ-017 Input changes after LOAD SHALL NOT affect the result in progress.
REQ-018 If en_i_g is high again in the cycle after DONE→IDLE, a new operation SHALL start on that edge; there is no minimum idle gap.

Reset
REQ-019 While rst_i_g=1, asynchronously: state=IDLE, data_o=0, sonuc_done=0, accumulator=0, tap index=0, captured operands=0.
REQ-020 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL wait in IDLE for en_i_g.

Structure
REQ-021 A shared package gauss_pkg SHALL hold DW, ACCW, SHIFT, the kernel weight table (as shift amounts 0,1,0,1,2,1,0,1,0) and the FSM state enum.
REQ-022 One sub-module, gauss_tap_acc, SHALL be used: a sequential weighted accumulator with inputs clear, add-enable, pixel and shift amount, and a registered 12-bit sum output.
REQ-023 The FSM, operand capture and output registers SHALL reside in gauss_2.

Verification
REQ-024 All nine inputs = 255, en held high -> sonuc_done rises 12 cycles after en, data_o=255.
REQ-025 Inputs 10,20,30,40,50,60,70,80,90 -> data_o=50 (sum 800).
REQ-026 Centre only = 255, others 0 -> data_o=63 (truncation of 63.75); corner only = 16 -> data_o=1.
REQ-027 Keep en high 30 cycles past done -> sonuc_done stays 1 and data_o is stable; drop en -> sonuc_done=0 next cycle; re-raise en 3 cycles later -> new result follows after 12 cycles.
REQ-028 Assert rst_i_g at cycle 6 of an operation -> data_o=0 and sonuc_done=0 immediately; drop en at cycle 5 of an operation -> no done and data_o unchanged.
REQ-029 Change the inputs two cycles after LOAD -> the result reflects the values captured at LOAD.
